// File: rtl/attn_presoft_seq.sv
// rtl/attn_presoft_seq.sv - sequencer and score drain controller for the attention pre-softmax engine
module attn_presoft_seq #(
  parameter int T      = 4,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 4096,
  parameter int T_W    = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_d_len,
  input  logic [T-1:0]      cmd_pad_valid,
  input  logic              cmd_causal_en,
  output logic              ps_start,
  output logic [15:0]       ps_d_len,
  output logic [T-1:0]      ps_pad_valid,
  output logic              ps_causal_en,
  input  logic              ps_busy,
  input  logic              ps_done,
  output logic              ps_sc_re,
  output logic [T_W-1:0]    ps_sc_tq,
  output logic [T_W-1:0]    ps_sc_tk,
  input  logic [DATA_W-1:0] ps_scm_rdata,
  input  logic              ps_scm_rvalid,
  input  logic              ps_row_max_valid,
  input  logic [DATA_W-1:0] ps_row_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [T_W-1:0]    out_tq,
  output logic [T_W-1:0]    out_tk,
  output logic              out_row_last,
  output logic              out_mat_last,
  output logic [DATA_W-1:0] out_row_max,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, RD_ISSUE, RD_WAIT, RM_WAIT, OUT, FIN
  } state_t;

  localparam int WD_W = $clog2(TO_CYC + 1);
  localparam logic [T_W-1:0] LAST = T_W'(T - 1);

  state_t            state, next_state;
  logic [T_W-1:0]    tq, tk;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] row_max_q;
  logic              rm_flag;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expire;
  logic              timeout;
  logic              rm_capture;
  logic              wait_state;
  logic              unused_busy;

  // Engine busy is informational only; the done handshake alone drives sequencing.
  assign unused_busy = ps_busy;

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign ps_start     = (state == START);
  assign ps_sc_re     = (state == RD_ISSUE);
  assign ps_sc_tq     = tq;
  assign ps_sc_tk     = tk;
  assign out_valid    = (state == OUT);
  assign out_data     = data_q;
  assign out_tq       = tq;
  assign out_tk       = tk;
  assign out_row_last = (state == OUT) && (tk == LAST);
  assign out_mat_last = (state == OUT) && (tk == LAST) && (tq == LAST);
  assign out_row_max  = row_max_q;
  assign done         = (state == FIN);

  assign wait_state = (state == WAIT_DONE) || (state == RD_WAIT) || (state == RM_WAIT);
  assign wd_expire  = (wd_cnt == WD_W'(TO_CYC - 1));

  // Row max is taken from the first read of a row until its last beat is presented;
  // the held last beat must not see its row max change underneath it.
  assign rm_capture = ps_row_max_valid &&
                      ((state == RD_ISSUE) || (state == RD_WAIT) || (state == RM_WAIT) ||
                       ((state == OUT) && (tk != LAST)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a wait that expires abandons the job without a done pulse.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      IDLE:      if (cmd_valid) next_state = START;
      START:     next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (ps_done)        next_state = RD_ISSUE;
        else if (wd_expire) begin next_state = IDLE; timeout = 1'b1; end
      end
      RD_ISSUE:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (ps_scm_rvalid) begin
          if ((tk == LAST) && !rm_flag && !ps_row_max_valid) next_state = RM_WAIT;
          else                                               next_state = OUT;
        end else if (wd_expire) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      RM_WAIT: begin
        if (ps_row_max_valid) next_state = OUT;
        else if (wd_expire)   begin next_state = IDLE; timeout = 1'b1; end
      end
      OUT: begin
        if (out_ready) begin
          if ((tq == LAST) && (tk == LAST)) next_state = FIN;
          else                              next_state = RD_ISSUE;
        end
      end
      FIN:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Command latch, beat indices, output register, row-max capture and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_d_len     <= '0;
      ps_pad_valid <= '0;
      ps_causal_en <= 1'b0;
      tq           <= '0;
      tk           <= '0;
      data_q       <= '0;
      row_max_q    <= '0;
      rm_flag      <= 1'b0;
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ps_d_len     <= cmd_d_len;
            ps_pad_valid <= cmd_pad_valid;
            ps_causal_en <= cmd_causal_en;
            err_timeout  <= 1'b0;
            tq           <= '0;
            tk           <= '0;
            rm_flag      <= 1'b0;
          end
        end
        RD_WAIT: if (ps_scm_rvalid) data_q <= ps_scm_rdata;
        OUT: begin
          if (out_ready) begin
            if (tk == LAST) begin
              tk      <= '0;
              tq      <= tq + T_W'(1);
              rm_flag <= 1'b0;
            end else begin
              tk <= tk + T_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (rm_capture) begin
        row_max_q <= ps_row_max;
        rm_flag   <= 1'b1;
      end
      if (timeout) err_timeout <= 1'b1;
      if (state != next_state) wd_cnt <= '0;
      else if (wait_state)     wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: doc/attn_presoft_seq.md
Name: attn_presoft_seq

Overview:
- Sequencer and drain controller for the attention pre-softmax engine (QK^T, scale, mask, row-max).
- Accepts one command (D_len, pad mask, causal flag) and pulses the engine's start, then waits for done.
- Reads the T x T masked scaled score array in row-major order through the engine's single-port score read interface and streams it to the softmax stage with valid/ready.
- Attaches each row's max, captured from the engine, to that row's last element.

Parameters:
- T, 4, sequence length (rows/cols of score matrix)
- DATA_W, 32, score / row-max width (fp32 bits)
- TO_CYC, 4096, watchdog limit in cycles for any engine wait
- T_W, (T<=1)?1:$clog2(T), token index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_d_len  in  16  head dimension for this job
- cmd_pad_valid  in  T  key padding valid mask
- cmd_causal_en  in  1  causal mask enable
- ps_start  out  1  one-cycle start pulse to engine
- ps_d_len  out  16  latched D_len
- ps_pad_valid  out  T  latched pad mask
- ps_causal_en  out  1  latched causal flag
- ps_busy  in  1  engine busy (monitor only)
- ps_done  in  1  engine done pulse/level
- ps_sc_re  out  1  score read request, one cycle
- ps_sc_tq  out  T_W  query row index
- ps_sc_tk  out  T_W  key column index
- ps_scm_rdata  in  DATA_W  masked score
- ps_scm_rvalid  in  1  read data valid
- ps_row_max_valid  in  1  row max valid pulse
- ps_row_max  in  DATA_W  row max value
- out_valid  out  1  score beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  score value
- out_tq  out  T_W  row of beat
- out_tk  out  T_W  column of beat
- out_row_last  out  1  beat is tk==T-1
- out_mat_last  out  1  beat is tq==tk==T-1
- out_row_max  out  DATA_W  row max; valid only when out_row_last
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after last beat accepted
- err_timeout  out  1  sticky; cleared by next accepted command

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State is IDLE; counters, latches and the output register are cleared. Reset mid-job aborts immediately; no done pulse is produced.
- States: IDLE, START, WAIT_DONE, RD_ISSUE, RD_WAIT, RM_WAIT, OUT, FIN.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_* into ps_* and clear err_timeout; set tq=tk=0; go to START.
- START: ps_start=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE: wait for ps_done==1, then go to RD_ISSUE. ps_done arriving in the same cycle as the transition into WAIT_DONE is also honoured.
- RD_ISSUE: ps_sc_re=1 with ps_sc_tq=tq and ps_sc_tk=tk for one cycle; go to RD_WAIT. Only one read is outstanding at a time.
- RD_WAIT: on ps_scm_rvalid, capture rdata into the output register.
  - If tk==T-1 and the row max is not yet captured, go to RM_WAIT.
  - Otherwise go to OUT.
- RM_WAIT: wait for ps_row_max_valid, then go to OUT.
- Row-max capture: ps_row_max_valid is sampled in every state from RD_ISSUE onward. Any pulse seen during the row's last read is captured and flagged, so a pulse coincident with rvalid is not lost.
- OUT: out_valid=1; data, indices, row_last, mat_last and row_max are held stable until out_ready.
  - On handshake, advance: tk++. At wrap (tk==T-1), tk=0, tq++ and the row-max flag clears.
  - After tq==T-1 && tk==T-1 is accepted, go to FIN; otherwise go to RD_ISSUE.
- FIN: done=1 for one cycle; go to IDLE.
- Throughput: 3 cycles per beat minimum at engine read latency 1 with no backpressure. Latency-insensitive to read latency ≥1.
- Watchdog:
  - A counter resets on entry to WAIT_DONE, RD_WAIT and RM_WAIT.
  - Reaching TO_CYC sets err_timeout, deasserts out_valid and returns to IDLE. No done pulse is produced.
  - The watchdog does not run in OUT, so downstream stall is unlimited.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- An unsolicited ps_scm_rvalid outside RD_WAIT is ignored.
- T=1 boundary: every beat has row_last=mat_last=1.

Test Plan:
- Full job, engine model with read latency 1: Q rows 1..16 row-major, K rows {1,2,3,4}, D_len=4, no mask.
  - Response: ps_start pulses once; 16 beats in order (0,0)..(3,3).
  - Every beat of row 0 = 0x41700000 (15.0); row 1 = 0x420C0000 (35.0).
  - row_last on tk=3 with out_row_max equal to the row value; mat_last on (3,3); done one cycle after its accept.
- Backpressure: out_ready low 5 cycles on beat (1,2) -> out_data/out_tq/out_tk stable; no ps_sc_re issued during the stall; no beat lost or duplicated.
- Row-max timing: row-max pulse coincident with rvalid of tk=3, then delayed 6 cycles on the next row -> correct value on both last beats; RM_WAIT entered only in the delayed case.
- Masks: cmd_pad_valid=4'b0111, cmd_causal_en=1 -> ps_pad_valid/ps_causal_en latched and stable for the whole job, unaffected by cmd_* changes mid-job.
- Watchdog: engine never asserts ps_done, TO_CYC=64 -> err_timeout=1 at cycle 64 of WAIT_DONE; return to IDLE with no done; a new command clears err_timeout and completes normally.
- Reset mid-stream: rst_n low during beat (2,1) -> all outputs at reset values asynchronously; the next command restarts at (0,0) with a fresh ps_start.
